// File: rtl/fp_csr_requester_if.sv
// Purpose : bundles the request/response channel, the FP-issue stall pair and the FCSR access port of fp_csr_requester.
// Latency : n/a (wires only).
// Backpressure: req_vld/req_rdy style on the request side; rsp_valid is held until rsp_ready.
// Modports: master = fp_csr_requester (serves requests, drives FCSR accesses);
//           slave  = its environment (decode/execute stage, FP pipe, FCSR register block).
interface fp_csr_requester_if;
    // request from decode/execute
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_data;
    logic        req_rs1_is_x0;
    logic [4:0]  req_zimm;
    // response back to execute (old CSR value for rd)
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    // FP pipe
    logic        fp_busy;
    logic        fp_stall;
    // FCSR register block
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (
        input  req_valid, req_funct3, req_addr, req_rs1_data, req_rs1_is_x0, req_zimm,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        input  fp_busy,
        output fp_stall,
        output csr_write, csr_addr, csr_wdata,
        input  csr_rdata
    );

    modport slave (
        output req_valid, req_funct3, req_addr, req_rs1_data, req_rs1_is_x0, req_zimm,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        output fp_busy,
        input  fp_stall,
        input  csr_write, csr_addr, csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/fp_csr_requester.sv
// Purpose : executes one Zicsr access to fflags/frm/fcsr: drain FP pipe, read, read-modify-write, return old value.
// Latency : response 4 cycles after accept with a write, 3 without, 1 when illegal; +1 per fp_busy drain cycle.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready; fp_stall holds FP issue while in flight.
// Ports: clock, reset_n (async, active low); bus = fp_csr_requester_if.master
//        (req_* request in, rsp_* response out, fp_busy/fp_stall, csr_* FCSR access).
module fp_csr_requester #(
    parameter int unsigned DRAIN_LIMIT = 255    // 1..65535 busy cycles tolerated in DRAIN
) (
    input  logic                 clock,
    input  logic                 reset_n,
    fp_csr_requester_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Timeout fires on the busy cycle that would make the count reach DRAIN_LIMIT.
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_LIMIT - 1);

    state_t      state;
    logic [1:0]  op_q;          // funct3[1:0]: 01 write, 10 set, 11 clear
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic        src_zero_q;
    logic [31:0] old_q;
    logic [15:0] drain_cnt;

    logic        req_illegal;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic [31:0] raw_new;
    logic [31:0] field_mask;
    logic [31:0] new_val;
    logic        write_needed;

    assign bus.req_ready = (state == IDLE);

    always_comb begin
        req_illegal  = !((bus.req_addr == 12'h001) || (bus.req_addr == 12'h002) ||
                         (bus.req_addr == 12'h003)) || (bus.req_funct3[1:0] == 2'b00);
        req_src      = bus.req_funct3[2] ? {27'd0, bus.req_zimm} : bus.req_rs1_data;
        req_src_zero = bus.req_funct3[2] ? (bus.req_zimm == 5'd0) : bus.req_rs1_is_x0;
    end

    // Read-modify-write value, only meaningful in READ where csr_rdata is valid.
    always_comb begin
        case (op_q)
            2'b01:   raw_new = src_q;
            2'b10:   raw_new = bus.csr_rdata | src_q;
            default: raw_new = bus.csr_rdata & ~src_q;
        endcase
        case (addr_q[1:0])
            2'b01:   field_mask = 32'h0000_001F;   // fflags
            2'b10:   field_mask = 32'h0000_0007;   // frm (reserved encodings pass through)
            default: field_mask = 32'h0000_00FF;   // fcsr
        endcase
        new_val      = raw_new & field_mask;
        // set/clear with a zero source must not write (no side effects on the FCSR)
        write_needed = (op_q == 2'b01) || !src_zero_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            op_q          <= 2'b00;
            addr_q        <= 12'h000;
            src_q         <= 32'd0;
            src_zero_q    <= 1'b0;
            old_q         <= 32'd0;
            drain_cnt     <= 16'd0;
            bus.fp_stall  <= 1'b0;
            bus.csr_write <= 1'b0;
            bus.csr_addr  <= 12'h000;
            bus.csr_wdata <= 32'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q       <= bus.req_funct3[1:0];
                        addr_q     <= bus.req_addr;
                        src_q      <= req_src;
                        src_zero_q <= req_src_zero;
                        old_q      <= 32'd0;
                        if (req_illegal) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= 32'd0;
                        end else begin
                            state        <= DRAIN;
                            drain_cnt    <= 16'd0;
                            bus.fp_stall <= 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (!bus.fp_busy) begin
                        state        <= READ;
                        bus.csr_addr <= addr_q;     // combinational read happens in READ
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state         <= RESP;
                        bus.fp_stall  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= 32'd0;
                    end else begin
                        drain_cnt <= drain_cnt + 16'd1;
                    end
                end

                READ: begin
                    old_q <= bus.csr_rdata;
                    if (write_needed) begin
                        state         <= WRITE;
                        bus.csr_write <= 1'b1;
                        bus.csr_wdata <= new_val;
                    end else begin
                        state         <= RESP;
                        bus.csr_addr  <= 12'h000;
                        bus.fp_stall  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= bus.csr_rdata;
                    end
                end

                WRITE: begin
                    state         <= RESP;
                    bus.csr_write <= 1'b0;
                    bus.csr_addr  <= 12'h000;
                    bus.csr_wdata <= 32'd0;
                    // FP issue resumes only once the write has landed
                    bus.fp_stall  <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= old_q;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= 32'd0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_csr_requester.sv
module tb_fp_csr_requester;

    logic clock;
    logic reset_n;
    logic [7:0] fcsr_m;     // FCSR block model: frm in [7:5], fflags in [4:0]

    fp_csr_requester_if bus();

    fp_csr_requester #(.DRAIN_LIMIT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        case (bus.csr_addr)
            12'h001: bus.csr_rdata = {27'd0, fcsr_m[4:0]};
            12'h002: bus.csr_rdata = {29'd0, fcsr_m[7:5]};
            12'h003: bus.csr_rdata = {24'd0, fcsr_m};
            default: bus.csr_rdata = 32'd0;
        endcase
    end

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic        x0;
        logic [4:0]  zimm;
        logic [7:0]  pre;     // FCSR contents before the access
        int          busy;    // fp_busy cycles at the start of DRAIN
        int          hold;    // cycles rsp_ready stays low
        int          lat;     // cycle index of first rsp_valid (accept edge = c0)
        logic        err;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int writes;
        int reads;
        logic done;
        logic stall_bad;
        logic hold_bad;
        logic [31:0] wd;
        logic [11:0] wa;
        logic [31:0] r_q;
        logic e_q;
        string tag;
        tag = $sformatf("v%0d", idx);
        writes = 0; reads = 0; done = 1'b0; stall_bad = 1'b0; hold_bad = 1'b0;
        wd = 32'd0; wa = 12'd0;

        @(negedge clock);
        fcsr_m = v.pre;
        bus.req_valid     = 1'b1;
        bus.req_funct3    = v.f3;
        bus.req_addr      = v.addr;
        bus.req_rs1_data  = v.rs1;
        bus.req_rs1_is_x0 = v.x0;
        bus.req_zimm      = v.zimm;
        chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(negedge clock);                // accept edge passed, now in c1
        bus.req_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (bus.rsp_valid) begin
                done = 1'b1;
            end else begin
                if (bus.csr_write) begin
                    writes++;
                    wd = bus.csr_wdata;
                    wa = bus.csr_addr;
                end else if (bus.csr_addr != 12'd0) begin
                    reads++;
                end
                if (!bus.fp_stall) stall_bad = 1'b1;
                bus.fp_busy = (cyc <= v.busy);
                @(negedge clock);
                cyc++;
            end
        end
        bus.fp_busy = 1'b0;
        if (!done) chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
        chk({tag, "_latency"}, cyc, v.lat);
        chk({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, v.err});
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, v.rdata);
        chk({tag, "_writes"}, writes, v.wr ? 1 : 0);
        chk({tag, "_reads"}, reads, (v.err || v.wr) ? (v.err ? 0 : 0) + (v.err ? 0 : 1) : 1);
        if (v.wr) begin
            chk({tag, "_wdata"}, wd, v.wdata);
            chk({tag, "_waddr"}, {20'd0, wa}, {20'd0, v.addr});
        end
        chk({tag, "_stall_inflight"}, {31'd0, stall_bad}, 32'd0);
        chk({tag, "_stall_resp"}, {31'd0, bus.fp_stall}, 32'd0);
        chk({tag, "_csr_idle_resp"}, bus.csr_wdata | {20'd0, bus.csr_addr} | {31'd0, bus.csr_write}, 32'd0);

        r_q = bus.rsp_rdata;
        e_q = bus.rsp_err;
        if (v.hold > 0) begin
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clock);
                if (!bus.rsp_valid || bus.rsp_rdata !== r_q || bus.rsp_err !== e_q || bus.req_ready)
                    hold_bad = 1'b1;
            end
            chk({tag, "_hold_stable"}, {31'd0, hold_bad}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        chk({tag, "_post_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_post_ready"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        logic quiet_bad;
        checks = 0;
        errors = 0;
        fcsr_m = 8'h00;
        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 12'h000;
        bus.req_rs1_data = 32'd0;
        bus.req_rs1_is_x0 = 1'b0;
        bus.req_zimm = 5'd0;
        bus.rsp_ready = 1'b0;
        bus.fp_busy = 1'b0;

        //          f3      addr     rs1            x0    zimm   pre    busy hold lat err   wr    wdata         rdata
        vt[0]  = '{3'b001, 12'h003, 32'hFFFF_FF25, 1'b0, 5'h00, 8'h00, 0,   0,   4,  1'b0, 1'b1, 32'h25, 32'h00};
        vt[1]  = '{3'b010, 12'h001, 32'h0000_0014, 1'b0, 5'h00, 8'h03, 0,   0,   4,  1'b0, 1'b1, 32'h17, 32'h03};
        vt[2]  = '{3'b110, 12'h001, 32'h0000_0000, 1'b0, 5'h00, 8'h17, 0,   0,   3,  1'b0, 1'b0, 32'h00, 32'h17};
        vt[3]  = '{3'b111, 12'h002, 32'h0000_0000, 1'b0, 5'h06, 8'h80, 0,   0,   4,  1'b0, 1'b1, 32'h00, 32'h04};
        vt[4]  = '{3'b001, 12'h300, 32'h0000_0055, 1'b0, 5'h00, 8'h5A, 0,   0,   1,  1'b1, 1'b0, 32'h00, 32'h00};
        vt[5]  = '{3'b100, 12'h001, 32'h0000_0055, 1'b0, 5'h00, 8'h5A, 0,   0,   1,  1'b1, 1'b0, 32'h00, 32'h00};
        vt[6]  = '{3'b000, 12'h003, 32'h0000_0055, 1'b0, 5'h00, 8'h5A, 0,   0,   1,  1'b1, 1'b0, 32'h00, 32'h00};
        vt[7]  = '{3'b011, 12'h003, 32'h0000_000F, 1'b0, 5'h00, 8'hFF, 0,   5,   4,  1'b0, 1'b1, 32'hF0, 32'hFF};
        vt[8]  = '{3'b010, 12'h001, 32'h0000_0000, 1'b1, 5'h00, 8'h1A, 0,   0,   3,  1'b0, 1'b0, 32'h00, 32'h1A};
        vt[9]  = '{3'b101, 12'h002, 32'h0000_0000, 1'b0, 5'h1D, 8'h00, 0,   0,   4,  1'b0, 1'b1, 32'h05, 32'h00};
        vt[10] = '{3'b001, 12'h002, 32'h0000_0007, 1'b0, 5'h00, 8'h20, 0,   0,   4,  1'b0, 1'b1, 32'h07, 32'h01};
        vt[11] = '{3'b001, 12'h001, 32'h0000_0000, 1'b1, 5'h00, 8'h1F, 0,   0,   4,  1'b0, 1'b1, 32'h00, 32'h1F};
        vt[12] = '{3'b110, 12'h003, 32'h0000_0000, 1'b0, 5'h1F, 8'hE0, 0,   0,   4,  1'b0, 1'b1, 32'hFF, 32'hE0};
        vt[13] = '{3'b001, 12'h000, 32'h0000_0001, 1'b0, 5'h00, 8'h11, 0,   2,   1,  1'b1, 1'b0, 32'h00, 32'h00};
        vt[14] = '{3'b001, 12'h003, 32'h0000_0025, 1'b0, 5'h00, 8'h00, 100, 0,   5,  1'b1, 1'b0, 32'h00, 32'h00};
        vt[15] = '{3'b010, 12'h001, 32'h0000_0001, 1'b0, 5'h00, 8'h10, 3,   0,   7,  1'b0, 1'b1, 32'h11, 32'h10};
        vt[16] = '{3'b001, 12'h003, 32'h0000_0025, 1'b0, 5'h00, 8'h00, 4,   0,   5,  1'b1, 1'b0, 32'h00, 32'h00};
        vt[17] = '{3'b111, 12'h001, 32'h0000_0000, 1'b0, 5'h03, 8'h1F, 0,   0,   4,  1'b0, 1'b1, 32'h1C, 32'h1F};

        // reset state
        repeat (2) @(negedge clock);
        chk("reset_outputs", {28'd0, bus.rsp_valid, bus.rsp_err, bus.fp_stall, bus.csr_write}, 32'd0);
        chk("reset_data", bus.rsp_rdata | bus.csr_wdata | {20'd0, bus.csr_addr}, 32'd0);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < NV; i++) run_vec(i, vt[i]);

        // reset asserted while the write strobe is up
        @(negedge clock);
        fcsr_m = 8'h00;
        bus.req_valid     = 1'b1;
        bus.req_funct3    = 3'b001;
        bus.req_addr      = 12'h003;
        bus.req_rs1_data  = 32'h0000_0042;
        bus.req_rs1_is_x0 = 1'b0;
        bus.req_zimm      = 5'd0;
        @(negedge clock);               // c1
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clock);    // c3 = WRITE
        chk("rst_mid_write_strobe", {31'd0, bus.csr_write}, 32'd1);
        chk("rst_mid_wdata", bus.csr_wdata, 32'h42);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_csr_write", {31'd0, bus.csr_write}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_fp_stall", {31'd0, bus.fp_stall}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        quiet_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (bus.rsp_valid || bus.csr_write || !bus.req_ready) quiet_bad = 1'b1;
        end
        chk("rst_mid_no_response", {31'd0, quiet_bad}, 32'd0);

        // normal operation after the aborted access
        run_vec(100, vt[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
